// File: rtl/input_pkg.sv
// rtl/input_pkg.sv - shared source and arbiter state types for the input path
package input_pkg;

    typedef enum logic [1:0] {
        SRC_PS2 = 2'd0,
        SRC_IR  = 2'd1,
        SRC_NES = 2'd2
    } src_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLAIM = 2'd1,
        ST_OWNED = 2'd2
    } arb_state_e;

    // Successor of a source in the fixed round-robin ring PS2 -> IR -> NES -> PS2.
    function automatic src_e src_next(input src_e s);
        case (s)
            SRC_PS2: src_next = SRC_IR;
            SRC_IR:  src_next = SRC_NES;
            default: src_next = SRC_PS2;
        endcase
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - round-robin choice of the first active source after the last owner
module rr_pick
    import input_pkg::*;
(
    input  logic [2:0] active,
    input  src_e       last_owner,
    output logic       valid,
    output src_e       pick
);

    src_e first_src;
    src_e second_src;

    assign first_src  = src_next(last_owner);
    assign second_src = src_next(first_src);

    // Search starts just after the last owner, so the last owner has lowest priority.
    always_comb begin
        valid = |active;
        pick  = SRC_PS2;
        if (active[first_src]) begin
            pick = first_src;
        end else if (active[second_src]) begin
            pick = second_src;
        end else if (active[last_owner]) begin
            pick = last_owner;
        end
    end

endmodule

// File: rtl/input_arbiter.sv
// rtl/input_arbiter.sv - grants the input decoder to one of PS/2, IR or NES controllers
module input_arbiter
    import input_pkg::*;
#(
    parameter int CLAIM_CYCLES = 4,
    parameter int HOLD_CYCLES  = 1000000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] PDir,
    input  logic       PReadable,
    input  logic [3:0] IDir,
    input  logic       IReadable,
    input  logic [3:0] NDir,
    input  logic       NReadable,
    output logic [1:0] Choice,
    output logic       Locked,
    output logic       Switched
);

    localparam int CW = $clog2(CLAIM_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES);
    localparam logic [CW-1:0] CLAIM_LAST = CW'(CLAIM_CYCLES - 1);
    localparam logic [CW-1:0] CLAIM_FULL = CW'(CLAIM_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);

    arb_state_e    state;
    src_e          cand;
    src_e          last_owner;
    src_e          choice_q;
    logic [CW-1:0] claim_cnt;
    logic [HW-1:0] idle_cnt;

    logic [2:0] readable;
    logic [2:0] active;
    logic       pick_valid;
    src_e       pick;

    assign readable = {NReadable, IReadable, PReadable};
    assign active   = readable & {|NDir, |IDir, |PDir};
    assign Choice   = choice_q;

    rr_pick u_rr_pick (
        .active     (active),
        .last_owner (last_owner),
        .valid      (pick_valid),
        .pick       (pick)
    );

    // Arbitration FSM: pick a candidate, make it prove steady activity, then hold until idle or unplugged.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state      <= ST_IDLE;
            cand       <= SRC_PS2;
            last_owner <= SRC_NES;
            choice_q   <= SRC_PS2;
            claim_cnt  <= '0;
            idle_cnt   <= '0;
            Locked     <= 1'b0;
            Switched   <= 1'b0;
        end else begin
            Switched <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        cand      <= pick;
                        claim_cnt <= '0;
                        state     <= ST_CLAIM;
                    end
                end
                ST_CLAIM: begin
                    if (!active[cand]) begin
                        claim_cnt <= '0;
                        state     <= ST_IDLE;
                    end else if (claim_cnt == CLAIM_LAST) begin
                        claim_cnt  <= CLAIM_FULL;
                        idle_cnt   <= '0;
                        choice_q   <= cand;
                        last_owner <= cand;
                        Locked     <= 1'b1;
                        Switched   <= 1'b1;
                        state      <= ST_OWNED;
                    end else begin
                        claim_cnt <= claim_cnt + CW'(1);
                    end
                end
                ST_OWNED: begin
                    // A disconnected owner releases at once; an idle one only after the hold window.
                    if (!readable[choice_q] || (!active[choice_q] && idle_cnt == HOLD_LAST)) begin
                        idle_cnt  <= '0;
                        claim_cnt <= '0;
                        Locked    <= 1'b0;
                        state     <= ST_IDLE;
                    end else if (active[choice_q]) begin
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + HW'(1);
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    Locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_input_arbiter.sv
// tb/tb_input_arbiter.sv - self-checking bench for input_arbiter
module tb_input_arbiter;

    localparam int CLAIM = 4;
    localparam int HOLD  = 8;

    logic       CLK;
    logic       RST_N;
    logic [3:0] PDir, IDir, NDir;
    logic       PReadable, IReadable, NReadable;
    logic [1:0] Choice;
    logic       Locked;
    logic       Switched;

    int total = 0;
    int bad   = 0;

    input_arbiter #(.CLAIM_CYCLES(CLAIM), .HOLD_CYCLES(HOLD)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .PDir      (PDir),
        .PReadable (PReadable),
        .IDir      (IDir),
        .IReadable (IReadable),
        .NDir      (NDir),
        .NReadable (NReadable),
        .Choice    (Choice),
        .Locked    (Locked),
        .Switched  (Switched)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst_n;
        logic [3:0] pd;
        logic       pr;
        logic [3:0] id;
        logic       ir;
        logic [3:0] nd;
        logic       nr;
        logic [1:0] c;
        logic       l;
        logic       s;
    } vec_t;

    vec_t tbl[12];

    int m_owner, m_cand, m_streak, m_idle, m_last, m_choice, m_sw;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [3:0] pd, input logic pr, input logic [3:0] id,
                          input logic ir, input logic [3:0] nd, input logic nr);
        PDir = pd; PReadable = pr;
        IDir = id; IReadable = ir;
        NDir = nd; NReadable = nr;
    endtask

    task automatic tick(input string name, input int c, input int l, input int s);
        @(posedge CLK);
        #1;
        chk({name, " choice"}, 32'(Choice), 32'(c));
        chk({name, " locked"}, 32'(Locked), 32'(l));
        chk({name, " switched"}, 32'(Switched), 32'(s));
    endtask

    // Reference: owner/candidate bookkeeping with run lengths counted in whole cycles.
    task automatic model_step(input bit rst, input bit [2:0] rdy, input bit [2:0] act);
        int k;
        if (rst) begin
            m_owner = -1; m_cand = -1; m_streak = 0; m_idle = 0;
            m_last = 2; m_choice = 0; m_sw = 0;
        end else begin
            m_sw = 0;
            if (m_owner >= 0) begin
                if (!rdy[m_owner]) begin
                    m_owner = -1; m_idle = 0;
                end else if (act[m_owner]) begin
                    m_idle = 0;
                end else begin
                    m_idle++;
                    if (m_idle == HOLD) begin
                        m_owner = -1; m_idle = 0;
                    end
                end
            end else if (m_cand >= 0) begin
                if (act[m_cand]) begin
                    m_streak++;
                    if (m_streak == CLAIM) begin
                        m_owner = m_cand; m_last = m_cand; m_choice = m_cand;
                        m_sw = 1; m_cand = -1;
                    end
                end else begin
                    m_cand = -1; m_streak = 0;
                end
            end else begin
                for (int i = 1; i <= 3; i++) begin
                    k = (m_last + i) % 3;
                    if (act[k] && m_cand < 0) begin
                        m_cand = k; m_streak = 0;
                    end
                end
            end
        end
    endtask

    initial begin
        bit [2:0]   rdy, act;
        logic [3:0] dv[3];
        bit         rst;

        RST_N = 1'b0;
        set_in(4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0);

        tbl[0]  = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 4'h8, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 4'h8, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 4'h8, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 4'h8, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 4'h8, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b1, 1'b1};
        tbl[6]  = '{1'b1, 4'h8, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 4'h8, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 4'h0, 1'b0, 4'h4, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 4'h0, 1'b0, 4'h4, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 4'h0, 1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0};

        @(posedge CLK);
        #1;
        for (int r = 0; r < 12; r++) begin
            RST_N = tbl[r].rst_n;
            set_in(tbl[r].pd, tbl[r].pr, tbl[r].id, tbl[r].ir, tbl[r].nd, tbl[r].nr);
            tick($sformatf("vec%0d", r), int'(tbl[r].c), int'(tbl[r].l), int'(tbl[r].s));
        end

        // All three active with last owner PS/2: IR wins, then NES after IR drops out.
        set_in(4'h8, 1'b1, 4'h4, 1'b1, 4'h2, 1'b1);
        for (int i = 0; i < 4; i++) tick("rr1 wait", 0, 0, 0);
        tick("rr1 grant", 1, 1, 1);
        tick("rr1 hold", 1, 1, 0);
        IReadable = 1'b0;
        tick("rr1 unplug", 1, 0, 0);
        IReadable = 1'b1;
        for (int i = 0; i < 4; i++) tick("rr2 wait", 1, 0, 0);
        tick("rr2 grant", 2, 1, 1);

        // NES disconnect releases on the next edge.
        NReadable = 1'b0;
        tick("nes unplug", 2, 0, 0);

        // PS/2 owns, goes idle while NES is busy: hold window then NES takes over.
        set_in(4'h1, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0);
        for (int i = 0; i < 4; i++) tick("ps2 wait", 2, 0, 0);
        tick("ps2 grant", 0, 1, 1);
        set_in(4'h0, 1'b1, 4'h0, 1'b0, 4'h1, 1'b1);
        for (int i = 0; i < HOLD - 1; i++) tick("ps2 idle hold", 0, 1, 0);
        tick("ps2 timeout", 0, 0, 0);
        for (int i = 0; i < 4; i++) tick("nes wait", 0, 0, 0);
        tick("nes grant", 2, 1, 1);

        // Reset in the middle of a claim.
        NReadable = 1'b0;
        tick("nes unplug2", 2, 0, 0);
        set_in(4'h2, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0);
        tick("claim a", 2, 0, 0);
        tick("claim b", 2, 0, 0);
        RST_N = 1'b0;
        tick("reset mid claim", 0, 0, 0);
        RST_N = 1'b1;
        set_in(4'h8, 1'b1, 4'h4, 1'b1, 4'h2, 1'b1);
        for (int i = 0; i < 4; i++) tick("post reset wait", 0, 0, 0);
        tick("post reset grant", 0, 1, 1);

        // Randomized traffic against the reference model.
        RST_N = 1'b0;
        model_step(1'b1, 3'b000, 3'b000);
        tick("rand reset", m_choice, 0, 0);
        RST_N = 1'b1;
        for (int k = 0; k < 3; k++) dv[k] = 4'h0;
        rdy = 3'b111;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int k = 0; k < 3; k++) begin
                if ($urandom_range(0, 39) == 0) rdy[k] = ~rdy[k];
                if ($urandom_range(0, 11) == 0)
                    dv[k] = (dv[k] == 4'h0) ? 4'($urandom_range(1, 15)) : 4'h0;
                act[k] = rdy[k] && (dv[k] != 4'h0);
            end
            rst = ($urandom_range(0, 299) == 0);
            RST_N = !rst;
            set_in(dv[0], rdy[0], dv[1], rdy[1], dv[2], rdy[2]);
            model_step(rst, rdy, act);
            tick($sformatf("rand%0d", cyc), m_choice, (m_owner >= 0) ? 1 : 0, m_sw);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
